dmem_lsu: RTL and testbench

//  Load/store unit: memory-side consumer of the EX-stage memory controls (mr/mw, address, store data).

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/dmem_lsu.sv | 156 +++++++++++++++
 tb/tb_dmem_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access encodings,
// FSM states and byte-lane helpers.
package lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      LSU_LB, LSU_LBU: be = 4'b0001 << off;
      LSU_LH, LSU_LHU: be = 4'b0011 << off;
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  // Sizes outside B/H/W (unused funct3 codes) are rejected like a misalignment.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3)
      LSU_LB, LSU_LBU: bad = 1'b0;
      LSU_LH, LSU_LHU: bad = off[0];
      LSU_LW:          bad = (off != 2'b00);
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] rep;
    case (funct3)
      LSU_LB, LSU_LBU: rep = {4{wdata[7:0]}};
      LSU_LH, LSU_LHU: rep = {2{wdata[15:0]}};
      default:         rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load type.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    case (offset_i)
      2'd0:    byteLane = rdata_i[7:0];
      2'd1:    byteLane = rdata_i[15:8];
      2'd2:    byteLane = rdata_i[23:16];
      default: byteLane = rdata_i[31:24];
    endcase
    halfLane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      LSU_LB:  data_o = {{24{byteLane[7]}}, byteLane};
      LSU_LBU: data_o = {24'h0, byteLane};
      LSU_LH:  data_o = {{16{halfLane[15]}}, halfLane};
      LSU_LHU: data_o = {16'h0, halfLane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: turns EX-stage memory controls into one req/gnt/rvalid bus
// transaction, stalls the pipeline while it is outstanding and returns the load word.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mr_i,
  input  logic        mw_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  localparam logic [TIMEOUT_W-1:0] TimeoutCnt = TIMEOUT_W'(TIMEOUT);

  lsu_state_e           state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [31:0]          addr_q, addr_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;

  logic                 accessReq;
  logic                 accessBad;
  logic [31:0]          loadWord;

  lsu_load_align u_align (
    .rdata_i  (data_rdata_i),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (loadWord)
  );

  assign accessReq = mr_i | mw_i;
  assign accessBad = (mr_i & mw_i) | misaligned(funct3_i, addr_i[1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wdog_q   <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    rdata_o      = '0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (accessReq) begin
          if (accessBad) begin
            done_o = 1'b1;
            err_o  = 1'b1;
          end else begin
            addr_d   = addr_i;
            funct3_d = funct3_i;
            we_d     = mw_i;
            be_d     = be_gen(funct3_i, addr_i[1:0]);
            wdata_d  = wdata_rep(funct3_i, wdata_i);
            stall_o  = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stall_o      = 1'b1;
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = be_q;
        data_addr_o  = {addr_q[31:2], 2'b00};
        data_wdata_o = wdata_q;
        if (data_gnt_i) begin
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end

      // A timeout completes like an errored response, so the pipeline is released too.
      ST_WAIT: begin
        if (data_rvalid_i) begin
          done_o  = 1'b1;
          err_o   = data_err_i;
          state_d = ST_IDLE;
          if (!data_err_i && !we_q) begin
            rdata_o = loadWord;
          end
        end else if (wdog_q == TimeoutCnt) begin
          done_o  = 1'b1;
          err_o   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          wdog_d  = wdog_q + TIMEOUT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs fed straight from EX inputs must also be silent while reset is held.
    if (!rst_ni) begin
      stall_o = 1'b0;
      done_o  = 1'b0;
      err_o   = 1'b0;
      rdata_o = '0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: hand-computed bus and pipeline responses for
// loads, stores, misalignment, timeout and reset-in-flight.
module tb_dmem_lsu;

  logic        clk_i;
  logic        rst_ni;
  logic        mr_i;
  logic        mw_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  int vecCount  = 0;
  int missCount = 0;
  int cycles;

  dmem_lsu #(.TIMEOUT_W(8), .TIMEOUT(255)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mr_i          (mr_i),
    .mw_i          (mw_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .data_err_i    (data_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    mr_i     = mr;
    mw_i     = mw;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Full transaction from accept to completion; called at a negedge with the DUT idle.
  task automatic busAccess(input string tag, input logic isWrite, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input int gntDelay,
                           input logic [31:0] rspData, input logic rspErr,
                           input logic [3:0] expBe, input logic [31:0] expWdata,
                           input logic [31:0] expRdata, input logic expErr);
    applyStimulus(!isWrite, isWrite, f3, addr, wdata);
    #1;
    checkOutput({tag, ".stallAccept"}, 32'(stall_o), 32'd1);
    checkOutput({tag, ".reqAccept"}, 32'(data_req_o), 32'd0);
    nextCycle();
    checkOutput({tag, ".req"}, 32'(data_req_o), 32'd1);
    checkOutput({tag, ".addr"}, data_addr_o, {addr[31:2], 2'b00});
    checkOutput({tag, ".be"}, 32'(data_be_o), 32'(expBe));
    checkOutput({tag, ".we"}, 32'(data_we_o), 32'(isWrite));
    checkOutput({tag, ".wdata"}, data_wdata_o, expWdata);
    checkOutput({tag, ".doneReq"}, 32'(done_o), 32'd0);
    for (int i = 0; i < gntDelay; i++) begin
      nextCycle();
      checkOutput({tag, ".reqHeld"}, 32'(data_req_o), 32'd1);
    end
    data_gnt_i = 1'b1;
    nextCycle();
    data_gnt_i = 1'b0;
    checkOutput({tag, ".reqDrop"}, 32'(data_req_o), 32'd0);
    checkOutput({tag, ".stallWait"}, 32'(stall_o), 32'd1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rspData;
    data_err_i    = rspErr;
    #1;
    checkOutput({tag, ".done"}, 32'(done_o), 32'd1);
    checkOutput({tag, ".err"}, 32'(err_o), 32'(expErr));
    checkOutput({tag, ".rdata"}, rdata_o, expRdata);
    checkOutput({tag, ".stallDone"}, 32'(stall_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;
    #1;
    checkOutput({tag, ".doneAfter"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);

    // Reset values, with a misaligned request present to show reset silences it.
    #12;
    checkOutput("rst.req", 32'(data_req_o), 32'd0);
    checkOutput("rst.stall", 32'(stall_o), 32'd0);
    checkOutput("rst.done", 32'(done_o), 32'd0);
    checkOutput("rst.err", 32'(err_o), 32'd0);
    checkOutput("rst.rdata", rdata_o, 32'h0);
    checkOutput("rst.be", 32'(data_be_o), 32'h0);
    checkOutput("rst.addr", data_addr_o, 32'h0);
    checkOutput("rst.wdata", data_wdata_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    nextCycle();

    busAccess("lw",  1'b0, 3'b010, 32'h104, 32'h0, 2, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    busAccess("lb",  1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFFFF, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    busAccess("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FFFFFF, 1'b0, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    busAccess("lh",  1'b0, 3'b001, 32'h102, 32'h0, 0, 32'hBEEF1234, 1'b0, 4'b1100, 32'h0, 32'hFFFFBEEF, 1'b0);
    busAccess("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'hBEEF9234, 1'b0, 4'b0011, 32'h0, 32'h00009234, 1'b0);
    busAccess("sh",  1'b1, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    busAccess("sb",  1'b1, 3'b000, 32'h501, 32'h000000A5, 1, 32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0);
    busAccess("sw",  1'b1, 3'b010, 32'h50C, 32'h01234567, 0, 32'h0, 1'b0, 4'b1111, 32'h01234567, 32'h0, 1'b0);

    // Misaligned word load and simultaneous read+write are rejected without a bus cycle.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    #1;
    checkOutput("mis.req", 32'(data_req_o), 32'd0);
    checkOutput("mis.err", 32'(err_o), 32'd1);
    checkOutput("mis.done", 32'(done_o), 32'd1);
    checkOutput("mis.stall", 32'(stall_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h103, 32'h0);
    #1;
    checkOutput("misH.err", 32'(err_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
    #1;
    checkOutput("both.req", 32'(data_req_o), 32'd0);
    checkOutput("both.err", 32'(err_o), 32'd1);
    checkOutput("both.done", 32'(done_o), 32'd1);
    checkOutput("both.stall", 32'(stall_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    checkOutput("both.stayIdle", 32'(data_req_o), 32'd0);

    // Watchdog: no response after grant.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    nextCycle();
    data_gnt_i = 1'b1;
    nextCycle();
    data_gnt_i = 1'b0;
    cycles = 0;
    while (done_o !== 1'b1 && cycles < 300) begin
      nextCycle();
      cycles++;
    end
    checkOutput("to.cycles", 32'(cycles), 32'd255);
    checkOutput("to.err", 32'(err_o), 32'd1);
    checkOutput("to.rdata", rdata_o, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h12345678;
    #1;
    checkOutput("to.strayDone", 32'(done_o), 32'd0);
    checkOutput("to.strayErr", 32'(err_o), 32'd0);
    nextCycle();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;

    // Reset while waiting for the response.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    nextCycle();
    data_gnt_i = 1'b1;
    nextCycle();
    data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rstWait.req", 32'(data_req_o), 32'd0);
    checkOutput("rstWait.stall", 32'(stall_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hCAFEF00D;
    #1;
    checkOutput("rstWait.ignored", 32'(done_o), 32'd0);
    nextCycle();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;

    busAccess("lwPost", 1'b0, 3'b010, 32'h700, 32'h0, 0, 32'h0BADC0DE, 1'b0, 4'b1111, 32'h0, 32'h0BADC0DE, 1'b0);
    busAccess("busErr", 1'b0, 3'b010, 32'h704, 32'h0, 0, 32'h55555555, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
